fir_coeff_loader: RTL and testbench

Host-side coefficient writer for the 4-bank FIR datapath. It stages up to 63 signed 16-bit taps in an internal buffer. It then replays them as a gap-free, one-tap-per-clock burst on the FIR controller's coefficient-update port, driving `CoeffUpdateFlag`, `AddrRam`, `WrDtRam` and `NumOfCoeff`. The burst is aligned to the 600 kHz sample strobe so the FIR controller is guaranteed idle when the flag rises.

---
 rtl/fir_coeff_loader.sv | 170 +++++++++++++++++
 tb/tb_fir_coeff_loader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_coeff_loader.sv
// Coefficient writer: stages K taps from the host, then replays them as a gap-free,
// strobe-aligned burst on the FIR controller's update port. Optional FIR_COEFF_SYM_EN: symmetric (half) load.
module fir_coeff_loader #(
  parameter int BUF_DEPTH = 64
) (
  input  logic        iClk12M,
  input  logic        iRst,
  input  logic        iEnSample600k,
  input  logic        iLoadStart,
  input  logic [5:0]  iLoadNum,
  input  logic        iLoadAbort,
  input  logic        iCoeffValid,
  input  logic [15:0] iCoeffData,
  output logic        oCoeffReady,
  output logic        oCoeffUpdateFlag,
  output logic [5:0]  oAddrRam,
  output logic [15:0] oWrDtRam,
  output logic [5:0]  oNumOfCoeff,
  output logic        oBusy,
  output logic        oLoadDone,
  output logic        oLoadErr
);

  typedef enum logic [1:0] {IDLE, FILL, ARMED, BURST} stateT;

  stateT       rState;
  logic        rCool;
  logic [5:0]  rK;
  logic [6:0]  rKp;
  logic [5:0]  rWrIdx;
  logic [6:0]  rCnt;
  logic [15:0] coeffBuf [BUF_DEPTH];

  logic [5:0]  hNum;
  logic [6:0]  kpNext;
  logic [5:0]  rdIdx;
  logic [15:0] tapData;
  logic        accept;
  logic        lastWord;

`ifdef FIR_COEFF_SYM_EN
  logic [6:0] kPlusOne;
  assign kPlusOne = {1'b0, rK} + 7'd1;
  assign hNum     = kPlusOne[6:1];
`else
  assign hNum = rK;
`endif

  // Round K up to a whole number of 4-tap bank rows.
  assign kpNext   = ({1'b0, iLoadNum} + 7'd3) & 7'b111_1100;
  assign accept   = iCoeffValid & oCoeffReady;
  assign lastWord = (rWrIdx + 6'd1) == hNum;

  // Burst cycle j (j >= 1) presents index j-1; index 0 is also used on the arming strobe.
  assign rdIdx = (rState == BURST) ? (rCnt[5:0] - 6'd1) : 6'd0;

  always_comb begin
    // NOTE: every path assigns tapData first so no latch is inferred.
    tapData = '0;
    if (rdIdx < hNum) begin
      tapData = coeffBuf[rdIdx];
    end
`ifdef FIR_COEFF_SYM_EN
    else if (rdIdx < rK) begin
      tapData = coeffBuf[rK - 6'd1 - rdIdx];
    end
`endif
  end

  // NOTE: the staging buffer is deliberately not reset; it is always fully rewritten before use.
  always_ff @(posedge iClk12M) begin
    if (accept) begin
      coeffBuf[rWrIdx] <= iCoeffData;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so the order of statements
  // below never changes what other registers see this cycle.
  always_ff @(posedge iClk12M) begin
    if (iRst) begin
      rState           <= IDLE;
      rCool            <= 1'b0;
      rK               <= '0;
      rKp              <= '0;
      rWrIdx           <= '0;
      rCnt             <= '0;
      oCoeffReady      <= 1'b0;
      oCoeffUpdateFlag <= 1'b0;
      oAddrRam         <= '0;
      oWrDtRam         <= '0;
      oNumOfCoeff      <= '0;
      oBusy            <= 1'b0;
      oLoadDone        <= 1'b0;
      oLoadErr         <= 1'b0;
    end else begin
      oLoadDone <= 1'b0;
      oLoadErr  <= 1'b0;
      if (iEnSample600k) begin
        rCool <= 1'b0;
      end

      case (rState)
        IDLE: begin
          if (iLoadStart) begin
            if (iLoadNum == 6'd0) begin
              oLoadErr <= 1'b1;
            end else begin
              rK          <= iLoadNum;
              rKp         <= kpNext;
              rWrIdx      <= '0;
              rState      <= FILL;
              oCoeffReady <= 1'b1;
              oBusy       <= 1'b1;
            end
          end
        end

        FILL: begin
          if (iLoadAbort) begin
            rState      <= IDLE;
            oCoeffReady <= 1'b0;
            oBusy       <= 1'b0;
          end else if (accept) begin
            rWrIdx <= rWrIdx + 6'd1;
            if (lastWord) begin
              rState      <= ARMED;
              oCoeffReady <= 1'b0;
            end
          end
        end

        ARMED: begin
          if (iLoadAbort) begin
            rState <= IDLE;
            oBusy  <= 1'b0;
          end else if (iEnSample600k && !rCool) begin
            rState           <= BURST;
            rCnt             <= 7'd1;
            oCoeffUpdateFlag <= 1'b1;
            oAddrRam         <= rdIdx;
            oWrDtRam         <= tapData;
            oNumOfCoeff      <= rK;
          end
        end

        BURST: begin
          if (rCnt <= rKp) begin
            // The cycle after the last flagged one keeps the final index for the controller's last write.
            oCoeffUpdateFlag <= (rCnt < rKp);
            oAddrRam         <= rdIdx;
            oWrDtRam         <= tapData;
            rCnt             <= rCnt + 7'd1;
          end else begin
            rState           <= IDLE;
            rCnt             <= '0;
            rCool            <= 1'b1;
            oCoeffUpdateFlag <= 1'b0;
            oAddrRam         <= '0;
            oWrDtRam         <= '0;
            oBusy            <= 1'b0;
            oLoadDone        <= 1'b1;
          end
        end

        default: rState <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Self-checking bench for fir_coeff_loader: directed scenarios with random tap data,
// compared cycle by cycle against a coefficient-vector model of the burst.
module tb_fir_coeff_loader;

  logic        iClk12M = 1'b0;
  logic        iRst = 1'b1;
  logic        iEnSample600k = 1'b0;
  logic        iLoadStart = 1'b0;
  logic [5:0]  iLoadNum = '0;
  logic        iLoadAbort = 1'b0;
  logic        iCoeffValid = 1'b0;
  logic [15:0] iCoeffData = '0;
  logic        oCoeffReady;
  logic        oCoeffUpdateFlag;
  logic [5:0]  oAddrRam;
  logic [15:0] oWrDtRam;
  logic [5:0]  oNumOfCoeff;
  logic        oBusy;
  logic        oLoadDone;
  logic        oLoadErr;

  fir_coeff_loader #(.BUF_DEPTH(64)) dut (
    .iClk12M(iClk12M), .iRst(iRst), .iEnSample600k(iEnSample600k),
    .iLoadStart(iLoadStart), .iLoadNum(iLoadNum), .iLoadAbort(iLoadAbort),
    .iCoeffValid(iCoeffValid), .iCoeffData(iCoeffData), .oCoeffReady(oCoeffReady),
    .oCoeffUpdateFlag(oCoeffUpdateFlag), .oAddrRam(oAddrRam), .oWrDtRam(oWrDtRam),
    .oNumOfCoeff(oNumOfCoeff), .oBusy(oBusy), .oLoadDone(oLoadDone), .oLoadErr(oLoadErr)
  );

  always #5 iClk12M = ~iClk12M;

  int          total = 0;
  int          bad = 0;
  bit          coolPending = 1'b0;
  logic [5:0]  numModel = '0;
  logic [15:0] host [64];
  logic [15:0] coef [64];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk12M);
    #1;
  endtask

  function automatic logic [16:0] ctl();
    return {oCoeffReady, oCoeffUpdateFlag, oBusy, oLoadDone, oLoadErr, oAddrRam, oNumOfCoeff};
  endfunction

  function automatic logic [16:0] mk(input logic r, input logic f, input logic b,
                                     input logic d, input logic e,
                                     input logic [5:0] a, input logic [5:0] n);
    return {r, f, b, d, e, a, n};
  endfunction

  function automatic int hostWords(input int k);
`ifdef FIR_COEFF_SYM_EN
    return (k + 1) / 2;
`else
    return k;
`endif
  endfunction

  task automatic start_load(input int k);
    iLoadStart = 1'b1;
    iLoadNum   = 6'(k);
    tick();
    iLoadStart = 1'b0;
    check($sformatf("start_k%0d", k), 32'(ctl()), 32'(mk(1, 0, 1, 0, 0, 6'd0, numModel)));
  endtask

  // Hands the host words over with random idle gaps and builds the full coefficient vector.
  task automatic fill(input int k);
    int h;
    h = hostWords(k);
    for (int i = 0; i < h; i++) begin
      iCoeffValid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
      iCoeffValid = 1'b1;
      iCoeffData  = host[i];
      for (int b = 0; b < 8 && !oCoeffReady; b++) tick();
      check($sformatf("fill_ready_k%0d_w%0d", k, i), 32'(oCoeffReady), 32'd1);
      tick();
    end
    iCoeffValid = 1'b0;
    for (int n = 0; n < k; n++) coef[n] = (n < h) ? host[n] : host[k - 1 - n];
    check($sformatf("armed_k%0d", k), 32'(ctl()), 32'(mk(0, 0, 1, 0, 0, 6'd0, numModel)));
  endtask

  // Arms the burst (skipping one strobe when a cooldown is owed) and checks every cycle.
  task automatic fire(input int k, input int rstAt);
    int kp;
    int idx;
    logic [15:0] expData;
    kp = ((k + 3) / 4) * 4;
    if (coolPending) begin
      repeat ($urandom_range(1, 4)) tick();
      iEnSample600k = 1'b1;
      tick();
      iEnSample600k = 1'b0;
      check($sformatf("cool_skip_k%0d", k), 32'(ctl()), 32'(mk(0, 0, 1, 0, 0, 6'd0, numModel)));
      coolPending = 1'b0;
    end
    repeat ($urandom_range(1, 4)) tick();
    iEnSample600k = 1'b1;
    tick();
    iEnSample600k = 1'b0;
    numModel = 6'(k);
    for (int j = 0; j <= kp + 1; j++) begin
      if (j > 0) tick();
      if (j <= kp) begin
        idx     = (j == 0) ? 0 : j - 1;
        expData = (idx < k) ? coef[idx] : 16'd0;
        check($sformatf("burst_k%0d_j%0d", k, j), 32'(ctl()),
              32'(mk(0, j < kp, 1, 0, 0, 6'(idx), numModel)));
        check($sformatf("data_k%0d_j%0d", k, j), 32'(oWrDtRam), 32'(expData));
      end else begin
        check($sformatf("done_k%0d", k), 32'(ctl()), 32'(mk(0, 0, 0, 1, 0, 6'd0, numModel)));
        check($sformatf("done_data_k%0d", k), 32'(oWrDtRam), 32'd0);
      end
      if (j == rstAt) begin
        iRst = 1'b1;
        tick();
        iRst = 1'b0;
        check("rst_mid_burst", 32'(ctl()), 32'd0);
        check("rst_mid_burst_data", 32'(oWrDtRam), 32'd0);
        numModel    = '0;
        coolPending = 1'b0;
        return;
      end
    end
    tick();
    check($sformatf("done_clear_k%0d", k), 32'(ctl()), 32'(mk(0, 0, 0, 0, 0, 6'd0, numModel)));
    coolPending = 1'b1;
  endtask

  task automatic random_host();
    for (int i = 0; i < 64; i++) host[i] = 16'($urandom);
  endtask

  initial begin
    int k;

    // Reset state
    repeat (3) tick();
    check("reset_ctl", 32'(ctl()), 32'd0);
    check("reset_data", 32'(oWrDtRam), 32'd0);
    iRst = 1'b0;
    tick();
    check("post_reset_ctl", 32'(ctl()), 32'd0);

    // Zero tap count is rejected
    iLoadStart = 1'b1;
    iLoadNum   = 6'd0;
    tick();
    iLoadStart = 1'b0;
    check("load_err_pulse", 32'(ctl()), 32'(mk(0, 0, 0, 0, 1, 6'd0, numModel)));
    tick();
    check("load_err_clear", 32'(ctl()), 32'(mk(0, 0, 0, 0, 0, 6'd0, numModel)));

    // Abort while filling
    random_host();
    start_load(6);
    iLoadAbort = 1'b1;
    tick();
    iLoadAbort = 1'b0;
    check("abort_fill", 32'(ctl()), 32'(mk(0, 0, 0, 0, 0, 6'd0, numModel)));

    // Abort coinciding with the arming strobe
    start_load(4);
    fill(4);
    iLoadAbort    = 1'b1;
    iEnSample600k = 1'b1;
    tick();
    iLoadAbort    = 1'b0;
    iEnSample600k = 1'b0;
    coolPending   = 1'b0;
    check("abort_armed", 32'(ctl()), 32'(mk(0, 0, 0, 0, 0, 6'd0, numModel)));
    check("abort_armed_data", 32'(oWrDtRam), 32'd0);
    tick();
    check("abort_no_done", 32'(ctl()), 32'(mk(0, 0, 0, 0, 0, 6'd0, numModel)));

    // K=8 with taps 1..8
    for (int i = 0; i < 8; i++) host[i] = 16'(i + 1);
    start_load(8);
    fill(8);
    fire(8, -1);

    // K=5 padded to 8; a start request while armed must be ignored
    random_host();
    start_load(5);
    fill(5);
    iLoadStart = 1'b1;
    iLoadNum   = 6'd9;
    tick();
    iLoadStart = 1'b0;
    check("start_ignored_armed", 32'(ctl()), 32'(mk(0, 0, 1, 0, 0, 6'd0, numModel)));
    fire(5, -1);

`ifdef FIR_COEFF_SYM_EN
    host[0] = 16'd10; host[1] = 16'd20; host[2] = 16'd30; host[3] = 16'd40;
    start_load(7);
    fill(7);
    fire(7, -1);
`endif

    // Random back-to-back loads, including the 1 and 63 extremes
    for (int r = 0; r < 5; r++) begin
      k = (r == 0) ? 1 : (r == 1) ? 63 : int'($urandom_range(1, 63));
      random_host();
      start_load(k);
      fill(k);
      fire(k, -1);
    end

    // Reset in burst cycle 3, then a fresh load
    random_host();
    start_load(12);
    fill(12);
    fire(12, 3);
    random_host();
    k = int'($urandom_range(1, 63));
    start_load(k);
    fill(k);
    fire(k, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
